// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: instruction codes,
// ALU/extender operation constants, FSM state encoding and decode class bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] INSTR_RTYPE_OP = 6'h00;
  localparam logic [5:0] INSTR_J_OP     = 6'h02;
  localparam logic [5:0] INSTR_JAL_OP   = 6'h03;
  localparam logic [5:0] INSTR_BEQ_OP   = 6'h04;
  localparam logic [5:0] INSTR_BNE_OP   = 6'h05;
  localparam logic [5:0] INSTR_ADDI_OP  = 6'h08;
  localparam logic [5:0] INSTR_SLTI_OP  = 6'h0A;
  localparam logic [5:0] INSTR_ORI_OP   = 6'h0D;
  localparam logic [5:0] INSTR_LUI_OP   = 6'h0F;
  localparam logic [5:0] INSTR_LW_OP    = 6'h23;
  localparam logic [5:0] INSTR_SW_OP    = 6'h2B;

  localparam logic [5:0] INSTR_SLL_FUNCT  = 6'h00;
  localparam logic [5:0] INSTR_SRL_FUNCT  = 6'h02;
  localparam logic [5:0] INSTR_SLLV_FUNCT = 6'h04;
  localparam logic [5:0] INSTR_SRLV_FUNCT = 6'h06;
  localparam logic [5:0] INSTR_JR_FUNCT   = 6'h08;
  localparam logic [5:0] INSTR_JALR_FUNCT = 6'h09;
  localparam logic [5:0] INSTR_ADD_FUNCT  = 6'h20;
  localparam logic [5:0] INSTR_ADDU_FUNCT = 6'h21;
  localparam logic [5:0] INSTR_SUB_FUNCT  = 6'h22;
  localparam logic [5:0] INSTR_SUBU_FUNCT = 6'h23;
  localparam logic [5:0] INSTR_AND_FUNCT  = 6'h24;
  localparam logic [5:0] INSTR_OR_FUNCT   = 6'h25;
  localparam logic [5:0] INSTR_NOR_FUNCT  = 6'h27;
  localparam logic [5:0] INSTR_SLT_FUNCT  = 6'h2A;
  localparam logic [5:0] INSTR_SLTU_FUNCT = 6'h2B;

  localparam logic [4:0] ALUOp_ADDU = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_SUBU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_AND  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd5;
  localparam logic [4:0] ALUOp_NOR  = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_SLTU = 5'd8;
  localparam logic [4:0] ALUOp_SLL  = 5'd9;
  localparam logic [4:0] ALUOp_SRL  = 5'd10;
  localparam logic [4:0] ALUOp_SLLV = 5'd11;
  localparam logic [4:0] ALUOp_SRLV = 5'd12;
  localparam logic [4:0] ALUOp_LUI  = 5'd13;
  localparam logic [4:0] ALUOp_EQL  = 5'd14;
  localparam logic [4:0] ALUOp_BNE  = 5'd15;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef struct packed {
    logic rtype;
    logic itype_alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic jreg;
    logic illegal;
    logic link;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of the latched opcode/funct into an instruction class,
// ALU operation and immediate-extension mode.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_t cls_o,
  output logic [4:0]   alu_ctrl_o,
  output logic [1:0]   ext_op_o
);

  always_comb begin
    cls_o      = '0;
    alu_ctrl_o = ALUOp_ADDU;
    ext_op_o   = EXT_ZERO;
    case (opcode_i)
      INSTR_RTYPE_OP: begin
        cls_o.rtype = 1'b1;
        case (funct_i)
          INSTR_ADDU_FUNCT: alu_ctrl_o = ALUOp_ADDU;
          INSTR_ADD_FUNCT:  alu_ctrl_o = ALUOp_ADD;
          INSTR_SUBU_FUNCT: alu_ctrl_o = ALUOp_SUBU;
          INSTR_SUB_FUNCT:  alu_ctrl_o = ALUOp_SUB;
          INSTR_AND_FUNCT:  alu_ctrl_o = ALUOp_AND;
          INSTR_OR_FUNCT:   alu_ctrl_o = ALUOp_OR;
          INSTR_NOR_FUNCT:  alu_ctrl_o = ALUOp_NOR;
          INSTR_SLT_FUNCT:  alu_ctrl_o = ALUOp_SLT;
          INSTR_SLTU_FUNCT: alu_ctrl_o = ALUOp_SLTU;
          INSTR_SLL_FUNCT:  alu_ctrl_o = ALUOp_SLL;
          INSTR_SRL_FUNCT:  alu_ctrl_o = ALUOp_SRL;
          INSTR_SLLV_FUNCT: alu_ctrl_o = ALUOp_SLLV;
          INSTR_SRLV_FUNCT: alu_ctrl_o = ALUOp_SRLV;
          INSTR_JR_FUNCT, INSTR_JALR_FUNCT: begin
            cls_o.rtype = 1'b0;
            cls_o.jreg  = 1'b1;
            cls_o.link  = (funct_i == INSTR_JALR_FUNCT);
          end
          default: begin
            cls_o.rtype   = 1'b0;
            cls_o.illegal = 1'b1;
          end
        endcase
      end
      INSTR_J_OP:   cls_o.jump = 1'b1;
      INSTR_JAL_OP: begin
        cls_o.jump = 1'b1;
        cls_o.link = 1'b1;
      end
      INSTR_BEQ_OP: begin
        cls_o.branch = 1'b1;
        alu_ctrl_o   = ALUOp_EQL;
        ext_op_o     = EXT_SIGNED;
      end
      INSTR_BNE_OP: begin
        cls_o.branch = 1'b1;
        alu_ctrl_o   = ALUOp_BNE;
        ext_op_o     = EXT_SIGNED;
      end
      INSTR_ADDI_OP: begin
        cls_o.itype_alu = 1'b1;
        alu_ctrl_o      = ALUOp_ADD;
        ext_op_o        = EXT_SIGNED;
      end
      INSTR_SLTI_OP: begin
        cls_o.itype_alu = 1'b1;
        alu_ctrl_o      = ALUOp_SLT;
        ext_op_o        = EXT_SIGNED;
      end
      INSTR_ORI_OP: begin
        cls_o.itype_alu = 1'b1;
        alu_ctrl_o      = ALUOp_OR;
      end
      INSTR_LUI_OP: begin
        cls_o.itype_alu = 1'b1;
        alu_ctrl_o      = ALUOp_LUI;
      end
      INSTR_LW_OP: begin
        cls_o.load = 1'b1;
        alu_ctrl_o = ALUOp_ADD;
        ext_op_o   = EXT_SIGNED;
      end
      INSTR_SW_OP: begin
        cls_o.store = 1'b1;
        alu_ctrl_o  = ALUOp_ADD;
        ext_op_o    = EXT_SIGNED;
      end
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences each instruction, waits on the memory
// handshake and raises sticky illegal-instruction and bus-timeout flags.
//   state  | meaning
//   IDLE   | one cycle after reset, all outputs low
//   FETCH  | read instruction, PC+4; latch opcode/funct on mem_ready
//   DECODE | precompute branch target; resolve jumps and illegal opcodes
//   EXEC   | ALU operation, address calculation or branch compare
//   MEM    | hold load/store strobe until mem_ready
//   WB     | one-cycle register file write
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 5,
  parameter int WAIT_CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               branch,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic [1:0]         ext_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem2reg,
  output logic [1:0]         pc_src,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_timeout
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;

  state_e                  state_q, state_d;
  logic [5:0]              opcode_q, funct_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    illegal_q, timeout_q;
  logic                    waiting, timeout_now;
  logic [4:0]              alu_op;
  instr_class_t            cls;
  logic [4:0]              dec_alu;
  logic [1:0]              dec_ext;

  mc_ctrl_decode u_decode (
    .opcode_i   (opcode_q),
    .funct_i    (funct_q),
    .cls_o      (cls),
    .alu_ctrl_o (dec_alu),
    .ext_op_o   (dec_ext)
  );

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    branch    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_op    = ALUOp_ADDU;
    ext_op    = EXT_ZERO;
    reg_dst   = 2'd0;
    mem2reg   = 2'd0;
    pc_src    = 2'd0;
    waiting   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = 2'd1;
        waiting   = !mem_ready;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALUOp_ADD;
        ext_op    = dec_ext;
        if (cls.illegal) begin
          state_d = S_FETCH;
        end else if (cls.jump || cls.jreg) begin
          pc_we   = 1'b1;
          pc_src  = cls.jump ? 2'd2 : 2'd3;
          reg_we  = cls.link;
          reg_dst = !cls.link ? 2'd0 : (cls.jump ? 2'd2 : 2'd1);
          mem2reg = cls.link ? 2'd2 : 2'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu;
        ext_op    = dec_ext;
        if (cls.branch) begin
          // PC write is qualified by the ALU zero flag in the datapath.
          branch  = 1'b1;
          pc_src  = 2'd1;
          state_d = S_FETCH;
        end else if (cls.load || cls.store) begin
          alu_src_b = 2'd2;
          state_d   = S_MEM;
        end else begin
          alu_src_b = cls.itype_alu ? 2'd2 : 2'd0;
          state_d   = S_WB;
        end
      end
      S_MEM: begin
        ext_op  = dec_ext;
        mem_re  = cls.load;
        mem_we  = cls.store;
        waiting = !mem_ready;
        if (mem_ready) state_d = cls.load ? S_WB : S_FETCH;
      end
      S_WB: begin
        ext_op  = dec_ext;
        reg_we  = 1'b1;
        reg_dst = cls.rtype ? 2'd1 : 2'd0;
        mem2reg = cls.load ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter is zero whenever not waiting, so every FETCH/MEM visit starts at 0.
  assign timeout_now = waiting && (wait_cnt_q == WAIT_MAX);
  assign wait_cnt_d  = !waiting ? '0 : (timeout_now ? WAIT_MAX : wait_cnt_q + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      funct_q    <= '0;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == S_FETCH && mem_ready) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (state_q == S_DECODE && cls.illegal) illegal_q <= 1'b1;
      if (timeout_now) timeout_q <= 1'b1;
    end
  end

  assign alu_ctrl    = ALUOP_W'(alu_op);
  assign state       = state_q;
  assign illegal     = illegal_q | ((state_q == S_DECODE) && cls.illegal);
  assign bus_timeout = timeout_q | timeout_now;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction expected cycle traces are
// built from the instruction rules and compared cycle by cycle against the DUT.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int ALUOP_W    = 5;
  localparam int WAIT_CNT_W = 4;
  localparam int TO_WAITS   = (1 << WAIT_CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [5:0]         opcode = '0;
  logic [5:0]         funct = '0;
  logic               mem_ready = 1'b0;
  logic               pc_we, ir_we, reg_we, mem_re, mem_we, branch, alu_src_a;
  logic [1:0]         alu_src_b, ext_op, reg_dst, mem2reg, pc_src;
  logic [ALUOP_W-1:0] alu_ctrl;
  logic [2:0]         state;
  logic               illegal, bus_timeout;

  mc_ctrl_fsm #(.ALUOP_W(ALUOP_W), .WAIT_CNT_W(WAIT_CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .branch(branch), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .ext_op(ext_op), .reg_dst(reg_dst), .mem2reg(mem2reg), .pc_src(pc_src),
    .state(state), .illegal(illegal), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we, ir_we, reg_we, mem_re, mem_we, branch, a;
    logic [1:0] b;
    logic [4:0] alu;
    logic [1:0] ext, rdst, m2r, pcs;
    logic       ill, to;
  } obs_t;

  typedef struct {
    int   rdy;   // 0/1 fixed mem_ready, 2 random
    bit   ld;    // present the instruction on opcode/funct this cycle
    obs_t e;
  } step_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JR, K_ILL} kind_e;
  typedef struct {
    kind_e      k;
    logic       link;
    logic [4:0] alu;
    logic [1:0] ext;
  } ref_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_ill   = 1'b0;
  logic m_to    = 1'b0;

  logic [11:0] instr_tbl [0:28] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24},
    {6'h00, 6'h25}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B}, {6'h00, 6'h00},
    {6'h00, 6'h02}, {6'h00, 6'h04}, {6'h00, 6'h06}, {6'h00, 6'h08}, {6'h00, 6'h09},
    {6'h0D, 6'h00}, {6'h08, 6'h00}, {6'h0A, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
    {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00},
    {6'h3F, 6'h00}, {6'h00, 6'h3F}, {6'h01, 6'h00}, {6'h00, 6'h01}
  };

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, pc_we: pc_we, ir_we: ir_we, reg_we: reg_we, mem_re: mem_re,
          mem_we: mem_we, branch: branch, a: alu_src_a, b: alu_src_b, alu: alu_ctrl,
          ext: ext_op, rdst: reg_dst, m2r: mem2reg, pcs: pc_src, ill: illegal,
          to: bus_timeout};
    return o;
  endfunction

  function automatic ref_t classify(input logic [5:0] op, input logic [5:0] fn);
    ref_t r;
    r.k = K_ILL; r.link = 1'b0; r.alu = ALUOp_ADDU; r.ext = EXT_ZERO;
    case (op)
      6'h00: begin
        r.k = K_R;
        case (fn)
          6'h21: r.alu = ALUOp_ADDU;
          6'h20: r.alu = ALUOp_ADD;
          6'h23: r.alu = ALUOp_SUBU;
          6'h22: r.alu = ALUOp_SUB;
          6'h24: r.alu = ALUOp_AND;
          6'h25: r.alu = ALUOp_OR;
          6'h27: r.alu = ALUOp_NOR;
          6'h2A: r.alu = ALUOp_SLT;
          6'h2B: r.alu = ALUOp_SLTU;
          6'h00: r.alu = ALUOp_SLL;
          6'h02: r.alu = ALUOp_SRL;
          6'h04: r.alu = ALUOp_SLLV;
          6'h06: r.alu = ALUOp_SRLV;
          6'h08: r.k = K_JR;
          6'h09: begin r.k = K_JR; r.link = 1'b1; end
          default: r.k = K_ILL;
        endcase
      end
      6'h02: r.k = K_J;
      6'h03: begin r.k = K_J; r.link = 1'b1; end
      6'h04: begin r.k = K_BR; r.alu = ALUOp_EQL; r.ext = EXT_SIGNED; end
      6'h05: begin r.k = K_BR; r.alu = ALUOp_BNE; r.ext = EXT_SIGNED; end
      6'h08: begin r.k = K_I;  r.alu = ALUOp_ADD; r.ext = EXT_SIGNED; end
      6'h0A: begin r.k = K_I;  r.alu = ALUOp_SLT; r.ext = EXT_SIGNED; end
      6'h0D: begin r.k = K_I;  r.alu = ALUOp_OR; end
      6'h0F: begin r.k = K_I;  r.alu = ALUOp_LUI; end
      6'h23: begin r.k = K_LW; r.alu = ALUOp_ADD; r.ext = EXT_SIGNED; end
      6'h2B: begin r.k = K_SW; r.alu = ALUOp_ADD; r.ext = EXT_SIGNED; end
      default: r.k = K_ILL;
    endcase
    return r;
  endfunction

  function automatic step_t mk_step(input int rdy, input bit ld, input obs_t e);
    step_t s;
    s.rdy = rdy; s.ld = ld; s.e = e;
    return s;
  endfunction

  // Builds the expected trace from FETCH entry, then drives and checks it.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit stop_in_mem);
    ref_t  r;
    step_t q[$];
    obs_t  e, got;
    r = classify(op, fn);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 3'd1; e.mem_re = 1'b1; e.b = 2'd1; e.alu = ALUOp_ADDU;
      if (i == fw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      if (i < fw && i >= TO_WAITS) m_to = 1'b1;
      e.ill = m_ill; e.to = m_to;
      q.push_back(mk_step((i == fw) ? 1 : 0, (i == fw), e));
    end
    e = '0; e.st = 3'd2; e.b = 2'd3; e.alu = ALUOp_ADD; e.ext = r.ext;
    if (r.k == K_ILL) m_ill = 1'b1;
    if (r.k == K_J || r.k == K_JR) begin
      e.pc_we = 1'b1;
      e.pcs   = (r.k == K_J) ? 2'd2 : 2'd3;
      if (r.link) begin
        e.reg_we = 1'b1; e.m2r = 2'd2;
        e.rdst   = (r.k == K_J) ? 2'd2 : 2'd1;
      end
    end
    e.ill = m_ill; e.to = m_to;
    q.push_back(mk_step(2, 1'b0, e));
    if (r.k == K_R || r.k == K_I || r.k == K_LW || r.k == K_SW || r.k == K_BR) begin
      e = '0; e.st = 3'd3; e.a = 1'b1; e.alu = r.alu; e.ext = r.ext;
      if (r.k == K_BR) begin e.branch = 1'b1; e.pcs = 2'd1; end
      else if (r.k != K_R) e.b = 2'd2;
      e.ill = m_ill; e.to = m_to;
      q.push_back(mk_step(2, 1'b0, e));
    end
    if (r.k == K_LW || r.k == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.st = 3'd4; e.ext = r.ext;
        e.mem_re = (r.k == K_LW); e.mem_we = (r.k == K_SW);
        if (i < mw && i >= TO_WAITS) m_to = 1'b1;
        e.ill = m_ill; e.to = m_to;
        q.push_back(mk_step((i == mw) ? 1 : 0, 1'b0, e));
      end
    end
    if (r.k == K_R || r.k == K_I || r.k == K_LW) begin
      e = '0; e.st = 3'd5; e.reg_we = 1'b1; e.ext = r.ext;
      e.rdst = (r.k == K_R) ? 2'd1 : 2'd0;
      e.m2r  = (r.k == K_LW) ? 2'd1 : 2'd0;
      e.ill = m_ill; e.to = m_to;
      q.push_back(mk_step(2, 1'b0, e));
    end
    foreach (q[k]) begin
      @(posedge clk); #1;
      mem_ready = (q[k].rdy == 2) ? 1'($urandom_range(0, 1)) : (q[k].rdy != 0);
      if (q[k].ld) begin
        opcode = op; funct = fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #2;
      got = sample();
      n_tests++;
      if (got !== q[k].e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, k, got, q[k].e);
      end
      if (stop_in_mem && q[k].e.st == 3'd4) return;
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23; #2;
    got = sample();
    n_tests++;
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_hold: got %h expected %h", got, obs_t'('0));
    end
    @(posedge clk); #1; rst = 1'b0; #2;
    got = sample();
    n_tests++;
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", got, obs_t'('0));
    end
    m_ill = 1'b0; m_to = 1'b0;
  endtask

  task automatic test_addu();
    run_instr("addu", 6'h00, 6'h21, 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 6'h23, 6'h00, 0, 3, 1'b0);
  endtask

  task automatic test_jal();
    run_instr("jal", 6'h03, 6'h00, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'h3F, 6'h00, 0, 0, 1'b0);
    run_instr("addu_after_ill", 6'h00, 6'h21, 1, 0, 1'b0);
  endtask

  task automatic test_fetch_timeout();
    run_instr("fetch_timeout", 6'h00, 6'h21, 20, 0, 1'b0);
    run_instr("after_timeout", 6'h0D, 6'h00, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [11:0] ent;
    logic [5:0]  op, fn;
    for (int n = 0; n < 40; n++) begin
      ent = instr_tbl[$urandom_range(0, 28)];
      op  = ent[11:6];
      fn  = (op == 6'h00) ? ent[5:0] : 6'($urandom);
      run_instr("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid_sw();
    obs_t got;
    run_instr("sw_pre_reset", 6'h2B, 6'h00, 0, 5, 1'b1);
    #1; rst = 1'b1; #1;
    got = sample();
    n_tests++;
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_mid_sw: got %h expected %h", got, obs_t'('0));
    end
    m_ill = 1'b0; m_to = 1'b0;
    @(posedge clk); #1; rst = 1'b0; #2;
    got = sample();
    n_tests++;
    if (got !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_mid_sw_idle: got %h expected %h", got, obs_t'('0));
    end
    run_instr("sw_after_reset", 6'h2B, 6'h00, 0, 1, 1'b0);
  endtask

  task automatic test_mem_timeout();
    run_instr("lw_mem_timeout", 6'h23, 6'h00, 1, 17, 1'b0);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_jal();
    test_illegal();
    test_fetch_timeout();
    test_back_to_back();
    test_reset_mid_sw();
    test_mem_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
